gpu_copy_cv_seg: RTL and testbench
==================================

Name: gpu_copy_cv_seg

Overview:
- Parametrised successor to the pair-based CPU->VRAM copy sequencer.
- Consumes a 16-bit pixel stream from the GP0 data FIFO for a CPU-to-VRAM rectangle copy.
- Packs pixels into aligned VRAM segments of SEG_PIX pixels with per-pixel write masks, and issues one memory write command per segment.
- Sits between the command decoder/data FIFO and the memory command FIFO. Handles arbitrary X alignment, X/Y wrap-around and the PS1 "size 0 = max" rule.

Parameters:
- SEG_PIX, 8, pixels per memory segment; power of 2, range 2..16.
- PIX_W, 16, pixel width in bits.
- XW, 10, VRAM X coordinate width (1024 pixels).
- YW, 9, VRAM Y coordinate width (512 lines).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_start  in  1  one-cycle start pulse; honoured only in IDLE.
- i_x0  in  XW  rectangle origin X.
- i_y0  in  YW  rectangle origin Y.
- i_w  in  XW  width; 0 means 1024.
- i_h  in  YW  height; 0 means 512.
- i_pix_valid  in  1  data FIFO has a pixel.
- i_pix  in  PIX_W  pixel data.
- o_pix_ready  out  1  pixel consumed this cycle when both ready and valid are 1.
- o_cmd_valid  out  1  segment write request.
- i_cmd_ready  in  1  memory command FIFO accepts.
- o_cmd_segx  out  XW-log2(SEG_PIX)  segment column.
- o_cmd_y  out  YW  line.
- o_cmd_data  out  SEG_PIX*PIX_W  lane i at bits [i*PIX_W +: PIX_W].
- o_cmd_mask  out  SEG_PIX  per-lane write enable.
- o_active  out  1  not IDLE.
- o_done  out  1  one-cycle pulse after the last segment is accepted.

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is asynchronous, active-high.
- Reset values: state IDLE; o_pix_ready, o_cmd_valid, o_cmd_mask, o_active, o_done all 0; data register 0.
- States:
  - IDLE -> LOAD on i_start.
  - LOAD (1 cycle): latch x0/y0; set width W = (i_w==0 ? 1024 : i_w) and height H = (i_h==0 ? 512 : i_h), each held one bit wider. Set cx=x0, cy=y0, colLeft=W, rowLeft=H, mask=0. -> FILL.
  - FILL:
    - o_pix_ready=1. On accept: write i_pix to lane cx[L-1:0] (L=log2 SEG_PIX) and set that mask bit; cx=cx+1 mod 2^XW; colLeft-1.
    - -> ISSUE when the accepted lane is SEG_PIX-1 or colLeft becomes 0.
    - No accept while i_pix_valid=0; state and registers hold.
  - ISSUE:
    - o_cmd_valid=1 with segx=(cx of last accepted pixel)>>L, y=cy, and data/mask stable until i_cmd_ready.
    - On handshake: mask cleared.
    - If colLeft!=0 -> FILL.
    - Else if rowLeft==1 -> DONE.
    - Else cy=cy+1 mod 2^YW, cx=x0, colLeft=W, rowLeft-1 -> FILL.
  - DONE: o_done=1 for 1 cycle -> IDLE.
- o_active=1 in every state except IDLE.
- Alignment: the first segment of each line has mask bits only from lane x0[L-1:0] up. The last segment has bits only up to the last pixel's lane. Lanes with mask 0 carry don't-care data.
- X wrap (1023->0) always coincides with lane SEG_PIX-1, so the segment is issued before the wrap; no segment ever mixes two VRAM columns. Y wraps 511->0.
- Latency: the first command is asserted 1 cycle after the pixel completing the segment is accepted. Peak rate is SEG_PIX pixels per SEG_PIX+1 cycles.
- FIFO pixels are consumed only in FIFO order; no look-ahead and no purge. Any trailing odd-word padding is the decoder's responsibility.
- i_start outside IDLE is ignored.
- Asserting i_rst mid-copy aborts immediately: no o_done, no partial command.

Optional Feature:
- Macro GPU_COPY_MASKBIT_EN.
- Defined: adds inputs i_setMask and i_checkMask, latched in LOAD.
  - i_setMask forces bit PIX_W-1 of every written pixel to 1.
  - i_checkMask adds output o_cmd_preserveMasked, asserted with o_cmd_valid; memory then skips destination pixels whose bit 15 is set.
- Undefined: ports absent; pixels pass unmodified.

Decomposition:
- gpu_def package: state enum copyCvState_t (IDLE, LOAD, FILL, ISSUE, DONE), VRAM_XW/VRAM_YW constants, and function segLane(x).
- One natural sub-module: gpu_copy_cv_seg_packer, holding the lane data register and mask with write-lane and clear.

Test Plan:
- x0=0, y0=0, w=8, h=1, SEG_PIX=8, pixels 0x1000..0x1007 -> one command: segx=0, y=0, mask=0xFF, lane i=0x1000+i; o_done 1 cycle later.
- x0=5, w=6, h=2 -> per line: segx=0 mask=0xE0, then segx=1 mask=0x07; lines y=0 and y=1; 4 commands total.
- x0=1020, y0=511, w=8, h=2 -> line 511: segx=127 mask=0xF0, segx=0 mask=0x0F; then the same on y=0.
- i_w=0, i_h=0 -> 1024/8 × 512 = 65536 commands, all mask=0xFF; o_done once.
- Hold i_cmd_ready=0 for 20 cycles during ISSUE -> data/mask/segx stable, o_pix_ready=0, no pixel lost.
- Assert i_rst after 3 pixels of w=8 -> all outputs 0 asynchronously; a new i_start copy then completes normally.

Source files
------------

// File: rtl/gpu_copy_cv_seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpu_def : shared types and helpers for the CPU->VRAM segment copy path.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package gpu_def;

    localparam int VRAM_XW = 10;
    localparam int VRAM_YW = 9;
    localparam int LANE_W  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FILL  = 3'd2,
        ISSUE = 3'd3,
        DONE  = 3'd4
    } copyCvState_t;

    // Lane of pixel column x inside a segment of 2**lBits pixels.
    function automatic logic [LANE_W-1:0] segLane(input logic [15:0] x, input int unsigned lBits);
        logic [15:0] m;
        m = 16'((32'd1 << lBits) - 32'd1);
        return LANE_W'(x & m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_copy_cv_seg_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpu_copy_cv_seg_packer : lane data register and write mask of one segment. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gpu_copy_cv_seg_packer
    import gpu_def::*;
#(
    parameter int SEG_PIX = 8,
    parameter int PIX_W   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr,
    input  logic [LANE_W-1:0]        i_lane,
    input  logic [PIX_W-1:0]         i_pix,
    input  logic                     i_clr,
    output logic [SEG_PIX*PIX_W-1:0] o_data,
    output logic [SEG_PIX-1:0]       o_mask
);

    logic [SEG_PIX*PIX_W-1:0] r_data;
    logic [SEG_PIX-1:0]       r_mask;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
            r_mask <= '0;
        end else begin
            for (int i = 0; i < SEG_PIX; i++) begin
                if (i_clr) begin
                    r_mask[i] <= 1'b0;
                end else if (i_wr && (i_lane == LANE_W'(i))) begin
                    r_mask[i]                  <= 1'b1;
                    r_data[i*PIX_W +: PIX_W]   <= i_pix;
                end
            end
        end
    end

    assign o_data = r_data;
    assign o_mask = r_mask;

endmodule
`default_nettype wire

// File: rtl/gpu_copy_cv_seg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpu_copy_cv_seg : packs a CPU->VRAM pixel stream into masked VRAM segment  |
// | writes. Optional macro GPU_COPY_MASKBIT_EN adds set/check mask-bit support.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gpu_copy_cv_seg
    import gpu_def::*;
#(
    parameter int SEG_PIX = 8,
    parameter int PIX_W   = 16,
    parameter int XW      = VRAM_XW,
    parameter int YW      = VRAM_YW
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [XW-1:0]                 i_x0,
    input  logic [YW-1:0]                 i_y0,
    input  logic [XW-1:0]                 i_w,
    input  logic [YW-1:0]                 i_h,
    input  logic                          i_pix_valid,
    input  logic [PIX_W-1:0]              i_pix,
    output logic                          o_pix_ready,
    output logic                          o_cmd_valid,
    input  logic                          i_cmd_ready,
`ifdef GPU_COPY_MASKBIT_EN
    input  logic                          i_setMask,
    input  logic                          i_checkMask,
    output logic                          o_cmd_preserveMasked,
`endif
    output logic [XW-$clog2(SEG_PIX)-1:0] o_cmd_segx,
    output logic [YW-1:0]                 o_cmd_y,
    output logic [SEG_PIX*PIX_W-1:0]      o_cmd_data,
    output logic [SEG_PIX-1:0]            o_cmd_mask,
    output logic                          o_active,
    output logic                          o_done
);

    localparam int L = $clog2(SEG_PIX);

    copyCvState_t     r_state;
    logic             r_pixReady;
    logic             r_cmdValid;
    logic             r_done;
    logic [XW-1:0]    r_x0;
    logic [XW:0]      r_w;
    logic [XW-1:0]    r_cx;
    logic [YW-1:0]    r_cy;
    logic [XW:0]      r_colLeft;
    logic [YW:0]      r_rowLeft;
    logic [XW-L-1:0]  r_segx;

    logic [XW:0]        w_wFull;
    logic [YW:0]        w_hFull;
    logic [LANE_W-1:0]  w_lane;
    logic               w_accept;
    logic               w_handshake;
    logic               w_clr;
    logic [PIX_W-1:0]   w_pixIn;

    assign w_wFull     = (i_w == '0) ? {1'b1, {XW{1'b0}}} : {1'b0, i_w};
    assign w_hFull     = (i_h == '0) ? {1'b1, {YW{1'b0}}} : {1'b0, i_h};
    assign w_lane      = segLane(16'(r_cx), L);
    assign w_accept    = r_pixReady && i_pix_valid;
    assign w_handshake = r_cmdValid && i_cmd_ready;
    assign w_clr       = (r_state == LOAD) || w_handshake;

`ifdef GPU_COPY_MASKBIT_EN
    logic r_setMask;
    logic r_checkMask;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_setMask   <= 1'b0;
            r_checkMask <= 1'b0;
        end else if (r_state == LOAD) begin
            r_setMask   <= i_setMask;
            r_checkMask <= i_checkMask;
        end
    end

    assign w_pixIn              = {i_pix[PIX_W-1] | r_setMask, i_pix[PIX_W-2:0]};
    assign o_cmd_preserveMasked = r_cmdValid && r_checkMask;
`else
    assign w_pixIn = i_pix;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_pixReady <= 1'b0;
            r_cmdValid <= 1'b0;
            r_done     <= 1'b0;
            r_x0       <= '0;
            r_w        <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_colLeft  <= '0;
            r_rowLeft  <= '0;
            r_segx     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) r_state <= LOAD;
                LOAD: begin
                    r_x0       <= i_x0;
                    r_w        <= w_wFull;
                    r_cx       <= i_x0;
                    r_cy       <= i_y0;
                    r_colLeft  <= w_wFull;
                    r_rowLeft  <= w_hFull;
                    r_pixReady <= 1'b1;
                    r_state    <= FILL;
                end
                FILL: if (w_accept) begin
                    r_cx      <= r_cx + 1'b1;
                    r_colLeft <= r_colLeft - 1'b1;
                    r_segx    <= r_cx[XW-1:L];
                    // Wrap of X always lands on the last lane, so a segment never spans it.
                    if ((w_lane == LANE_W'(SEG_PIX-1)) || (r_colLeft == 1)) begin
                        r_pixReady <= 1'b0;
                        r_cmdValid <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: if (i_cmd_ready) begin
                    r_cmdValid <= 1'b0;
                    if (r_colLeft != '0) begin
                        r_pixReady <= 1'b1;
                        r_state    <= FILL;
                    end else if (r_rowLeft == 1) begin
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_cy       <= r_cy + 1'b1;
                        r_cx       <= r_x0;
                        r_colLeft  <= r_w;
                        r_rowLeft  <= r_rowLeft - 1'b1;
                        r_pixReady <= 1'b1;
                        r_state    <= FILL;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    gpu_copy_cv_seg_packer #(
        .SEG_PIX (SEG_PIX),
        .PIX_W   (PIX_W)
    ) u_packer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_wr   (w_accept),
        .i_lane (w_lane),
        .i_pix  (w_pixIn),
        .i_clr  (w_clr),
        .o_data (o_cmd_data),
        .o_mask (o_cmd_mask)
    );

    assign o_pix_ready = r_pixReady;
    assign o_cmd_valid = r_cmdValid;
    assign o_cmd_segx  = r_segx;
    assign o_cmd_y     = r_cy;
    assign o_active    = (r_state != IDLE);
    assign o_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_gpu_copy_cv_seg.sv
`default_nettype none
// Directed bench for gpu_copy_cv_seg with a pixel-level expected-command model.
module tb_gpu_copy_cv_seg;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [9:0]   x0 = '0;
    logic [8:0]   y0 = '0;
    logic [9:0]   w = '0;
    logic [8:0]   h = '0;
    logic         pixValid = 1'b0;
    logic [15:0]  pix = '0;
    logic         pixReady;
    logic         cmdValid;
    logic         cmdReady = 1'b1;
    logic [6:0]   segx;
    logic [8:0]   cy;
    logic [127:0] data;
    logic [7:0]   mask;
    logic         active;
    logic         done;
`ifdef GPU_COPY_MASKBIT_EN
    logic         setMask = 1'b0;
    logic         checkMask = 1'b0;
    logic         preserve;
`endif

    int nAssert = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    gpu_copy_cv_seg dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_x0        (x0),
        .i_y0        (y0),
        .i_w         (w),
        .i_h         (h),
        .i_pix_valid (pixValid),
        .i_pix       (pix),
        .o_pix_ready (pixReady),
        .o_cmd_valid (cmdValid),
        .i_cmd_ready (cmdReady),
`ifdef GPU_COPY_MASKBIT_EN
        .i_setMask   (setMask),
        .i_checkMask (checkMask),
        .o_cmd_preserveMasked (preserve),
`endif
        .o_cmd_segx  (segx),
        .o_cmd_y     (cy),
        .o_cmd_data  (data),
        .o_cmd_mask  (mask),
        .o_active    (active),
        .o_done      (done)
    );

    typedef struct packed {
        logic [6:0]   segx;
        logic [8:0]   y;
        logic [7:0]   mask;
        logic [127:0] data;
    } cmd_t;

    cmd_t expQ[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] laneMask(input logic [7:0] m);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (m[i]) r[i*16 +: 16] = 16'hFFFF;
        return r;
    endfunction

    // Walk every pixel of the rectangle and group consecutive ones by VRAM segment.
    task automatic buildExp(input int ax0, input int ay0, input int aw, input int ah, input int base);
        cmd_t cur;
        int   x, seg, lane, curSeg;
        cur = '0;
        curSeg = -1;
        for (int r = 0; r < ah; r++) begin
            for (int k = 0; k < aw; k++) begin
                x    = (ax0 + k) % 1024;
                seg  = x / 8;
                lane = x % 8;
                if (k == 0 || seg != curSeg) begin
                    if (k != 0) expQ.push_back(cur);
                    cur      = '0;
                    cur.segx = 7'(seg);
                    cur.y    = 9'((ay0 + r) % 512);
                    curSeg   = seg;
                end
                cur.mask[lane]          = 1'b1;
                cur.data[lane*16 +: 16] = 16'(base + r*aw + k);
            end
            expQ.push_back(cur);
        end
    endtask

    task automatic runCopy(input int ax0, input int ay0, input int aw, input int ah, input int base,
                           input bit gaps, input int stall, input int expFirst, input int expDone);
        cmd_t         e;
        int           nExp, nCmd, dones, firstIt, doneIt, pixCnt, stallLeft;
        bit           finished;
        logic [127:0] snapD;
        logic [7:0]   snapM;
        logic [6:0]   snapS;
        expQ.delete();
        buildExp(ax0, ay0, aw, ah, base);
        nExp = expQ.size();
        nCmd = 0; dones = 0; firstIt = -1; doneIt = -1; pixCnt = 0; stallLeft = stall;
        finished = 1'b0;
        snapD = '0; snapM = '0; snapS = '0;
        @(negedge clk);
        x0 = 10'(ax0);
        y0 = 9'(ay0);
        w  = (aw == 1024) ? 10'd0 : 10'(aw);
        h  = (ah == 512)  ? 9'd0  : 9'(ah);
        start = 1'b1;
        @(posedge clk);
        for (int it = 1; it <= 30000 && !finished; it++) begin
            @(negedge clk);
            start    = 1'b0;
            pixValid = gaps ? ((it % 3) != 0) : 1'b1;
            pix      = 16'(base + pixCnt);
            if (it == 1) chk("activeLoad", 128'(active), 128'd1);
            if (cmdValid && stallLeft > 0) begin
                cmdReady = 1'b0;
                if (stallLeft == stall) begin
                    snapD = data; snapM = mask; snapS = segx;
                end else begin
                    chk("stallData", data, snapD);
                    chk("stallMask", 128'(mask), 128'(snapM));
                    chk("stallSegx", 128'(segx), 128'(snapS));
                end
                chk("stallPixReady", 128'(pixReady), 128'd0);
                stallLeft--;
            end else begin
                cmdReady = 1'b1;
            end
            if (cmdValid && cmdReady) begin
                nCmd++;
                if (firstIt < 0) firstIt = it;
                if (expQ.size() == 0) begin
                    chk("extraCmd", 128'd1, 128'd0);
                end else begin
                    e = expQ.pop_front();
                    chk("segx", 128'(segx), 128'(e.segx));
                    chk("y",    128'(cy),   128'(e.y));
                    chk("mask", 128'(mask), 128'(e.mask));
                    chk("data", data & laneMask(mask), e.data);
                end
            end
            if (done) begin
                dones++;
                doneIt = it;
            end else if (doneIt > 0) begin
                finished = 1'b1;
                chk("activeIdle", 128'(active), 128'd0);
            end
            if (pixReady && pixValid) pixCnt++;
        end
        pixValid = 1'b0;
        cmdReady = 1'b1;
        chk("finished", 128'(finished), 128'd1);
        chk("nCmd",     128'(nCmd),     128'(nExp));
        chk("doneCnt",  128'(dones),    128'd1);
        chk("pixCnt",   128'(pixCnt),   128'(aw*ah));
        if (expFirst > 0) chk("firstLatency", 128'(firstIt), 128'(expFirst));
        if (expDone > 0)  chk("doneLatency",  128'(doneIt),  128'(expDone));
    endtask

    initial begin
        int cnt;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rstPixReady", 128'(pixReady), 128'd0);
        chk("rstCmdValid", 128'(cmdValid), 128'd0);
        chk("rstMask",     128'(mask),     128'd0);
        chk("rstActive",   128'(active),   128'd0);
        chk("rstDone",     128'(done),     128'd0);
        chk("rstData",     data,           128'd0);
        rst = 1'b0;

        runCopy(0,    0,   8,    1,   'h1000, 1'b0, 0,  10, 11);
        runCopy(5,    0,   6,    2,   'h2000, 1'b1, 0,  -1, -1);
        runCopy(1020, 511, 8,    2,   'h4000, 1'b0, 0,  -1, -1);
        runCopy(0,    3,   16,   1,   'h5000, 1'b0, 20, -1, -1);

        // Abort mid-copy after three accepted pixels
        @(negedge clk);
        x0 = 10'd0; y0 = 9'd0; w = 10'd8; h = 9'd1; start = 1'b1;
        @(posedge clk);
        cnt = 0;
        for (int it = 0; it < 20 && cnt < 3; it++) begin
            @(negedge clk);
            start    = 1'b0;
            pixValid = 1'b1;
            pix      = 16'(16'h3000 + cnt);
            if (pixReady) cnt++;
        end
        chk("abortPixCnt", 128'(cnt), 128'd3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abortPixReady", 128'(pixReady), 128'd0);
        chk("abortCmdValid", 128'(cmdValid), 128'd0);
        chk("abortMask",     128'(mask),     128'd0);
        chk("abortActive",   128'(active),   128'd0);
        chk("abortDone",     128'(done),     128'd0);
        chk("abortData",     data,           128'd0);
        pixValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        runCopy(2,    7,   8,    1,   'h6000, 1'b0, 0,  -1, -1);
        runCopy(3,    100, 1024, 1,   'h7000, 1'b0, 0,  -1, -1);
        runCopy(8,    10,  8,    512, 'h8000, 1'b0, 0,  -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire
